selftest_reporter: RTL and testbench
====================================

// Module: selftest_reporter
// PURPOSE
//   Transmit side of the self-test result interface: consumes done/result pairs from N test units
//   and sends one 8N1 serial status frame per run, so results of on-FPGA tests reach a host.
//   Sits between the register/ram test units and the board TX pin; simulation benches decode tx.
//   Aggregation rule: overall done = AND of all dones; overall fail = OR of all results.
// PARAMETERS
//   NUM_TESTS       2     number of test units, 1..8
//   CLKS_PER_BIT    16    clk cycles per serial bit, >=2
//   TIMEOUT_CYCLES  1024  cycles in WAIT before giving up on missing dones, >=2
// PORTS
//   clk          in   1          system clock, all state on rising edge
//   reset        in   1          asynchronous, active-high; returns block to IDLE
//   start        in   1          1-cycle pulse; begins a run (ignored unless IDLE or DONE)
//   test_done    in   NUM_TESTS  per-unit done, level
//   test_result  in   NUM_TESTS  per-unit result, 1 = fail; sampled while its done is high
//   tx           out  1          serial line, idle high, LSB first, 8N1
//   busy         out  1          high in WAIT and SEND
//   all_done     out  1          high in DONE
//   fail         out  1          valid in DONE: any latched fail or timeout
// BEHAVIOUR
//   Reset values: tx=1, busy=0, all_done=0, fail=0, sticky masks=0, state IDLE.
//   States: IDLE -> WAIT -> SEND -> DONE; DONE -> WAIT on start. No other transitions.
//   IDLE: wait for start. start in IDLE/DONE: clear masks, timer, fail; next state WAIT.
//   WAIT: each cycle, for each i with test_done[i]=1: done_mask[i]<=1, fail_mask[i]<=fail_mask[i]|test_result[i].
//     Masks are sticky; a done that later drops still counts as done.
//     Leave when (done_mask|test_done) is all ones (same-cycle inputs count) or timer==TIMEOUT_CYCLES-1.
//     Timer increments every WAIT cycle; timeout sets timed_out=1. Both on same cycle: completion wins.
//   SEND: frame latched on WAIT exit; tx start bit low on first SEND cycle (1-cycle latency from exit).
//     Byte0: 0x50 'P' if fail_mask==0 and !timed_out, else 0x46 'F'.
//     Byte1: fail_mask zero-extended to 8 bits. Byte2: done_mask zero-extended (0 bits = missing unit).
//     Byte3: 0x0A. Each byte: start(0), d0..d7, stop(1); each bit exactly CLKS_PER_BIT cycles.
//     Frame = 40*CLKS_PER_BIT cycles, bytes back-to-back; start ignored in SEND.
//   DONE: entered cycle after last stop bit ends; tx=1, all_done=1, fail=|fail_mask|timed_out, held.
//   Inputs are ignored outside WAIT. Reset mid-frame: tx returns high immediately (async), no resume.
//   Bit counter wraps per byte; byte counter 0..3 stops at 3, never wraps into a 5th byte.
// TESTING
//   1 NUM_TESTS=2, start, done=2'b11 result=0 at cycle 5 -> frame 50 00 03 0A, fail=0, all_done.
//   2 done[0] at cycle 3 with result 1, done[1] at 10 result 0 -> frame 46 01 03 0A, fail=1.
//   3 done[1] only, never done[0] -> exit after TIMEOUT_CYCLES, frame 46 00 02 0A, fail=1.
//   4 done[0] pulses 1 cycle then drops, done[1] later -> still completes, done byte 03.
//   5 reset asserted mid byte1 -> tx=1, busy=0 same cycle; new start sends full fresh frame.
//   6 start during SEND ignored; start in DONE reruns; bit widths measured = CLKS_PER_BIT each.

Source files
------------

// File: rtl/selftest_reporter.sv
// selftest_reporter: gathers done/result pairs from NUM_TESTS test units and
// sends one four-byte 8N1 status frame per run ('P'/'F', fail mask, done mask, LF).
//
// Control semantics: start is a one-cycle pulse, honoured only in IDLE or DONE;
// there is no ready/valid handshake. busy is high while a run is in progress, and
// start pulses that arrive while busy are dropped. test_done/test_result are
// levels that are sampled only in WAIT.
module selftest_reporter #(
  parameter int NUM_TESTS      = 2,
  parameter int CLKS_PER_BIT   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_result,
  output logic                 tx,
  output logic                 busy,
  output logic                 all_done,
  output logic                 fail,
  output logic [1:0]           o_dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] LP_CLK_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] LP_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           r_state;
  logic [NUM_TESTS-1:0] r_done_mask;
  logic [NUM_TESTS-1:0] r_fail_mask;
  logic [TW-1:0]        r_timer;
  logic                 r_timed_out;
  logic [CW-1:0]        r_clk_cnt;
  logic [3:0]           r_bit_cnt;
  logic [1:0]           r_byte_cnt;

  logic                 w_start_ok;
  logic                 w_complete;
  logic                 w_timeout;
  logic                 w_wait_exit;
  logic                 w_bit_end;
  logic                 w_byte_end;
  logic                 w_frame_end;
  logic [7:0]           w_byte;
  logic [2:0]           w_data_idx;
  logic                 w_tx_bit;

  // Same-cycle dones count toward completion; completion beats timeout.
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_complete  = &(r_done_mask | test_done);
  assign w_timeout   = (r_timer == LP_TIMER_LAST);
  assign w_wait_exit = (r_state == ST_WAIT) && (w_complete || w_timeout);

  assign w_bit_end   = (r_state == ST_SEND) && (r_clk_cnt == LP_CLK_LAST);
  assign w_byte_end  = w_bit_end && (r_bit_cnt == 4'd9);
  assign w_frame_end = w_byte_end && (r_byte_cnt == 2'd3);

  // Current frame byte; masks are frozen outside WAIT, so the frame is stable in SEND.
  always_comb begin
    w_byte = 8'h0A;
    case (r_byte_cnt)
      2'd0:    w_byte = ((r_fail_mask == '0) && !r_timed_out) ? 8'h50 : 8'h46;
      2'd1:    w_byte = 8'(r_fail_mask);
      2'd2:    w_byte = 8'(r_done_mask);
      default: w_byte = 8'h0A;
    endcase
  end

  // Bit slot 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
  assign w_data_idx = 3'(r_bit_cnt - 4'd1);
  always_comb begin
    w_tx_bit = 1'b1;
    if (r_bit_cnt == 4'd0)      w_tx_bit = 1'b0;
    else if (r_bit_cnt == 4'd9) w_tx_bit = 1'b1;
    else                        w_tx_bit = w_byte[w_data_idx];
  end

  assign tx          = (r_state == ST_SEND) ? w_tx_bit : 1'b1;
  assign busy        = (r_state == ST_WAIT) || (r_state == ST_SEND);
  assign all_done    = (r_state == ST_DONE);
  assign fail        = (r_state == ST_DONE) && ((|r_fail_mask) || r_timed_out);
  assign o_dbg_state = r_state;

  // Run control: state transitions, sticky masks, WAIT timer and timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_done_mask <= '0;
      r_fail_mask <= '0;
      r_timer     <= '0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state     <= ST_WAIT;
            r_done_mask <= '0;
            r_fail_mask <= '0;
            r_timer     <= '0;
            r_timed_out <= 1'b0;
          end
        end
        ST_WAIT: begin
          r_done_mask <= r_done_mask | test_done;
          r_fail_mask <= r_fail_mask | (test_done & test_result);
          r_timer     <= r_timer + 1'b1;
          if (w_complete) begin
            r_state <= ST_SEND;
          end else if (w_timeout) begin
            r_state     <= ST_SEND;
            r_timed_out <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_frame_end) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Serializer position: cycles within a bit, bit within a byte, byte within the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (w_wait_exit) begin
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (r_state == ST_SEND) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        if (w_byte_end) begin
          r_bit_cnt <= '0;
          if (r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_selftest_reporter.sv
// Directed bench for selftest_reporter: decodes the tx line cycle by cycle and
// compares each received byte, bit framing and status outputs against hand values.
module tb_selftest_reporter;

  localparam int NT  = 2;
  localparam int CPB = 16;
  localparam int TO  = 1024;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [NT-1:0] test_done;
  logic [NT-1:0] test_result;
  logic          tx;
  logic          busy;
  logic          all_done;
  logic          fail;
  logic [1:0]    o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  selftest_reporter #(
    .NUM_TESTS(NT), .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .test_done(test_done), .test_result(test_result),
    .tx(tx), .busy(busy), .all_done(all_done), .fail(fail),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Advance negedge by negedge until tx is low, within a cycle budget.
  task automatic wait_tx_low(input string tag, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  // Receive four bytes starting at the current negedge (first start-bit cycle);
  // every cycle of every bit must carry the same level.
  task automatic recv_frame(input string tag);
    logic [9:0] bits;
    logic       samp;
    bit         first;
    bit         width_ok;
    logic [7:0] exp_b;
    first = 1'b1;
    for (int b = 0; b < 4; b++) begin
      width_ok = 1'b1;
      bits = '0;
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < CPB; c++) begin
          if (!first) @(negedge clk);
          first = 1'b0;
          samp = tx;
          if (c == 0) bits[j] = samp;
          else if (samp !== bits[j]) width_ok = 1'b0;
        end
      end
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check($sformatf("%s_byte%0d", tag, b), {24'd0, bits[8:1]}, {24'd0, exp_b});
      check($sformatf("%s_framing%0d", tag, b),
            {29'd0, width_ok, bits[0], bits[9]}, 32'b101);
    end
  endtask

  task automatic check_done(input string tag, input logic exp_fail);
    @(negedge clk);
    check({tag, "_all_done"}, {31'd0, all_done}, 32'd1);
    check({tag, "_fail"},     {31'd0, fail},     {31'd0, exp_fail});
    check({tag, "_idle_out"}, {30'd0, busy, tx}, 32'b01);
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(8'h0A);
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; start = 1'b0; test_done = '0; test_result = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {28'd0, tx, busy, all_done, fail}, 32'b1000);
    check("rst_state",   {30'd0, o_dbg_state}, {30'd0, ST_IDLE});
    reset = 1'b0;

    // Inputs ignored in IDLE without start
    test_done = 2'b11; test_result = 2'b11;
    repeat (5) @(negedge clk);
    check("idle_ignores_inputs", {29'd0, tx, o_dbg_state}, {29'd0, 1'b1, ST_IDLE});
    test_done = '0; test_result = '0;

    // T1: both pass after a few WAIT cycles
    pulse_start();
    repeat (4) @(negedge clk);
    check("t1_wait_busy", {29'd0, busy, tx, all_done}, 32'b110);
    test_done = 2'b11; test_result = 2'b00;
    push_frame(8'h50, 8'h00, 8'h03);
    wait_tx_low("t1_start_latency", 1);
    test_done = '0;
    recv_frame("t1");
    check_done("t1", 1'b0);

    // T2: unit0 fails early, unit1 passes later; rerun from DONE.
    // A start pulse and input changes during SEND must not disturb the frame.
    pulse_start();
    repeat (2) @(negedge clk);
    test_done = 2'b01; test_result = 2'b01;
    repeat (7) @(negedge clk);
    test_done = 2'b11; test_result = 2'b01;
    push_frame(8'h46, 8'h01, 8'h03);
    wait_tx_low("t2_start_latency", 1);
    test_done = 2'b00; test_result = 2'b11;
    fork
      recv_frame("t2");
      begin
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check_done("t2", 1'b1);
    test_result = '0;

    // T3: unit0 never finishes, timeout after TO WAIT cycles
    test_done = 2'b10;
    pulse_start();
    repeat (TO - 1) @(negedge clk);
    check("t3_still_waiting", {29'd0, tx, o_dbg_state}, {29'd0, 1'b1, ST_WAIT});
    push_frame(8'h46, 8'h00, 8'h02);
    wait_tx_low("t3_timeout_exit", 1);
    recv_frame("t3");
    check_done("t3", 1'b1);
    test_done = '0;

    // T4: done[0] pulses one cycle; a result while its done is low is ignored
    pulse_start();
    repeat (2) @(negedge clk);
    test_done = 2'b01; test_result = 2'b00;
    @(negedge clk);
    test_done = 2'b00; test_result = 2'b01;
    repeat (5) @(negedge clk);
    check("t4_sticky_wait", {29'd0, tx, o_dbg_state}, {29'd0, 1'b1, ST_WAIT});
    test_done = 2'b10; test_result = 2'b01;
    push_frame(8'h50, 8'h00, 8'h03);
    wait_tx_low("t4_start_latency", 1);
    test_done = '0; test_result = '0;
    recv_frame("t4");
    check_done("t4", 1'b0);

    // T5: async reset in the middle of byte1, then a fresh full frame
    test_done = 2'b11;
    pulse_start();
    wait_tx_low("t5_start_latency", 1);
    repeat (10 * CPB + 5) @(negedge clk);
    check("t5_mid_frame_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_async_reset", {28'd0, tx, busy, all_done, fail}, 32'b1000);
    check("t5_reset_state", {30'd0, o_dbg_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_resume", {29'd0, tx, o_dbg_state}, {29'd0, 1'b1, ST_IDLE});
    push_frame(8'h50, 8'h00, 8'h03);
    pulse_start();
    wait_tx_low("t5_fresh_latency", 1);
    test_done = '0;
    recv_frame("t5");
    check_done("t5", 1'b0);

    // Outputs hold in DONE
    repeat (20) @(negedge clk);
    check("done_hold", {29'd0, tx, all_done, busy}, 32'b110);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
